// File: rtl/baggage_drop_pkg.sv
// Shared definitions for the baggage-drop display path: digit geometry,
// segment bit order, glyph codes and the scan FSM state type.
package baggage_drop_pkg;

    localparam int SEG_W      = 7;
    localparam int NUM_DIGITS = 4;
    localparam int DIG_W      = $clog2(NUM_DIGITS);

    // Segment code with nothing lit (codes are active-high, {g..a}).
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    // Bit position of each segment inside a code.
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Decimal glyphs, shared with the baggage_drop producer.
    localparam logic [SEG_W-1:0] GLYPH_0 = 7'h3F;
    localparam logic [SEG_W-1:0] GLYPH_1 = 7'h06;
    localparam logic [SEG_W-1:0] GLYPH_2 = 7'h5B;
    localparam logic [SEG_W-1:0] GLYPH_3 = 7'h4F;
    localparam logic [SEG_W-1:0] GLYPH_4 = 7'h66;
    localparam logic [SEG_W-1:0] GLYPH_5 = 7'h6D;
    localparam logic [SEG_W-1:0] GLYPH_6 = 7'h7D;
    localparam logic [SEG_W-1:0] GLYPH_7 = 7'h07;
    localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;
    localparam logic [SEG_W-1:0] GLYPH_9 = 7'h6F;

    // One full display frame; index 3 is the leftmost digit.
    typedef logic [NUM_DIGITS-1:0][SEG_W-1:0] seg_frame_t;

    // Each digit slot is a short blanking window followed by the drive window.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    // BCD digit to glyph; anything above 9 shows blank.
    function automatic logic [SEG_W-1:0] glyph(input logic [3:0] v);
        case (v)
            4'd0:    glyph = GLYPH_0;
            4'd1:    glyph = GLYPH_1;
            4'd2:    glyph = GLYPH_2;
            4'd3:    glyph = GLYPH_3;
            4'd4:    glyph = GLYPH_4;
            4'd5:    glyph = GLYPH_5;
            4'd6:    glyph = GLYPH_6;
            4'd7:    glyph = GLYPH_7;
            4'd8:    glyph = GLYPH_8;
            4'd9:    glyph = GLYPH_9;
            default: glyph = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/scan_timebase.sv
// Scan timebase: slot counter, digit index, BLANK/DRIVE slot FSM, frame
// boundary and first-slot-of-frame flag. Digits scan 3 -> 2 -> 1 -> 0.
module scan_timebase
    import baggage_drop_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [DIG_W-1:0] digit_o,
    output scan_state_e      state_o,
    output logic             boundary_o,
    output logic             frame_first_o
);

    localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_BLANK = SLOT_W'(BLANK_CYCLES);
    localparam logic [DIG_W-1:0]  DIG_FIRST  = DIG_W'(NUM_DIGITS - 1);

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [DIG_W-1:0]  digit_q, digit_d;
    scan_state_e       state_q, state_d;
    logic              en_q;

    // Timebase registers; en_q remembers last cycle's enable to spot its rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q  <= '0;
            digit_q <= DIG_FIRST;
            state_q <= ST_BLANK;
            en_q    <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            digit_q <= digit_d;
            state_q <= state_d;
            en_q    <= en_i;
        end
    end

    // Next slot/digit; the FSM state follows the blanking window of the next slot.
    always_comb begin
        slot_d  = slot_q;
        digit_d = digit_q;
        if (!en_i) begin
            slot_d  = '0;
            digit_d = DIG_FIRST;
        end else if (slot_q == SLOT_LAST) begin
            slot_d  = '0;
            digit_d = digit_q - 1'b1;
        end else begin
            slot_d  = slot_q + 1'b1;
        end
        state_d = (slot_d < SLOT_BLANK) ? ST_BLANK : ST_DRIVE;
    end

    assign digit_o       = digit_q;
    assign state_o       = state_q;
    // A frame ends when digit 0's slot wraps, or restarts when scanning is re-enabled.
    assign boundary_o    = en_i && (((slot_q == SLOT_LAST) && (digit_q == '0)) || !en_q);
    assign frame_first_o = en_i && (slot_q == '0) && (digit_q == DIG_FIRST);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Four-digit common-anode scan driver: captures segment codes into a pending
// buffer, promotes them to the displayed shadow only at frame boundaries,
// and drives the multiplexed segment/anode bus with ghost blanking and blink.
module seven_seg_scan_driver
    import baggage_drop_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 4,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [SEG_W-1:0]      seven_seg1,
    input  logic [SEG_W-1:0]      seven_seg2,
    input  logic [SEG_W-1:0]      seven_seg3,
    input  logic [SEG_W-1:0]      seven_seg4,
    input  logic                  upd,
    input  logic                  drop_activated,
    output logic [SEG_W-1:0]      seg_n,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic                  frame_start
);

    localparam int FCNT_W = $clog2(BLINK_FRAMES) + 1;
    localparam logic [FCNT_W-1:0] FCNT_WRAP = FCNT_W'(BLINK_FRAMES);

    logic [DIG_W-1:0] digit;
    scan_state_e      state;
    logic             boundary;
    logic             frame_first;

    seg_frame_t codes_in;
    seg_frame_t pend_q, pend_d;
    seg_frame_t shadow_q, shadow_d;
    logic       pend_vld_q, pend_vld_d;

    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              phase_q, phase_d;

    logic [SEG_W-1:0]      seg_n_q, seg_n_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
    logic                  fs_q, fs_d;

    scan_timebase #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_tb (
        .clk           (clk),
        .rst_n         (rst_n),
        .en_i          (en),
        .digit_o       (digit),
        .state_o       (state),
        .boundary_o    (boundary),
        .frame_first_o (frame_first)
    );

    assign codes_in = {seven_seg1, seven_seg2, seven_seg3, seven_seg4};

    // All state registers; outputs reset to every anode off, every segment dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            shadow_q   <= '0;
            pend_vld_q <= 1'b0;
            fcnt_q     <= '0;
            phase_q    <= 1'b0;
            seg_n_q    <= ~SEG_BLANK;
            an_n_q     <= '1;
            fs_q       <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            shadow_q   <= shadow_d;
            pend_vld_q <= pend_vld_d;
            fcnt_q     <= fcnt_d;
            phase_q    <= phase_d;
            seg_n_q    <= seg_n_d;
            an_n_q     <= an_n_d;
            fs_q       <= fs_d;
        end
    end

    // Capture: updates land in pending and reach the shadow only at a boundary,
    // so a frame never mixes old and new digits. A strobe on the boundary wins.
    always_comb begin
        pend_d     = pend_q;
        shadow_d   = shadow_q;
        pend_vld_d = pend_vld_q;
        if (boundary) begin
            if (upd) begin
                shadow_d = codes_in;
            end else if (pend_vld_q) begin
                shadow_d = pend_q;
            end
            pend_vld_d = 1'b0;
        end else if (upd) begin
            pend_d     = codes_in;
            pend_vld_d = 1'b1;
        end
    end

    // Blink: count frames while the drop is active, flip phase every BLINK_FRAMES.
    always_comb begin
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (!en || !drop_activated) begin
            fcnt_d  = '0;
            phase_d = 1'b0;
        end else if (boundary) begin
            if (fcnt_q + 1'b1 == FCNT_WRAP) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d  = fcnt_q + 1'b1;
            end
        end
    end

    // Output decode: drive one anode and its code only in DRIVE of a visible frame.
    always_comb begin
        seg_n_d = ~SEG_BLANK;
        an_n_d  = '1;
        fs_d    = frame_first;
        if (en && (state == ST_DRIVE) && !phase_q) begin
            an_n_d[digit] = 1'b0;
            seg_n_d       = ~shadow_q[digit];
        end
    end

    assign seg_n       = seg_n_q;
    assign an_n        = an_n_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with REFRESH_DIV=8, BLANK_CYCLES=2,
// BLINK_FRAMES=2: an 8-cycle slot, a 32-cycle frame.
module tb_seven_seg_scan_driver;

    localparam logic [27:0] CODES_A = {7'h06, 7'h5B, 7'h4F, 7'h66};
    localparam logic [27:0] CODES_B = {4{7'h3F}};
    localparam logic [27:0] CODES_C = {4{7'h01}};
    localparam logic [27:0] CODES_F = {4{7'h7F}};
    localparam logic [27:0] CODES_D = {7'h6D, 7'h7D, 7'h07, 7'h6F};
    localparam logic [27:0] CODES_Z = '0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        upd;
    logic        drop;
    logic [27:0] din;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        frame_start;

    int n_run  = 0;
    int n_fail = 0;

    seven_seg_scan_driver #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .seven_seg1     (din[27:21]),
        .seven_seg2     (din[20:14]),
        .seven_seg3     (din[13:7]),
        .seven_seg4     (din[6:0]),
        .upd            (upd),
        .drop_activated (drop),
        .seg_n          (seg_n),
        .an_n           (an_n),
        .frame_start    (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    // Expected outputs after the k-th enabled edge (cycle j = k-1 of the scan).
    task automatic step_chk(input int k, input logic [27:0] codes, input bit blank);
        int         j, slot, d;
        logic [3:0] ea;
        logic [6:0] es;
        j    = k - 1;
        slot = j % 8;
        d    = 3 - ((j / 8) % 4);
        ea   = 4'hF;
        es   = 7'h7F;
        if (!blank && slot >= 2) begin
            ea[d] = 1'b0;
            es    = ~codes[d*7 +: 7];
        end
        chk($sformatf("an_n@%0d", k), {28'd0, an_n}, {28'd0, ea});
        chk($sformatf("seg_n@%0d", k), {25'd0, seg_n}, {25'd0, es});
        chk($sformatf("fs@%0d", k), {31'd0, frame_start}, {31'd0, (j % 32) == 0});
    endtask

    task automatic chk_blank(input string tag);
        chk({tag, "_an"}, {28'd0, an_n}, 32'hF);
        chk({tag, "_seg"}, {25'd0, seg_n}, 32'h7F);
        chk({tag, "_fs"}, {31'd0, frame_start}, 32'd0);
    endtask

    initial begin
        logic [27:0] exp_codes;
        bit          blank;
        rst_n = 1'b0;
        en    = 1'b1;
        upd   = 1'b0;
        drop  = 1'b0;
        din   = '0;

        // Reset values, then scan from reset and reset again mid-scan.
        repeat (3) @(posedge clk);
        #1 chk_blank("reset");
        rst_n = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            #1 step_chk(k, CODES_Z, 1'b0);
        end
        chk("pre_rst_an", {28'd0, an_n}, 32'hB);
        rst_n = 1'b0;
        #1 chk_blank("async_rst");

        // Capture a frame while disabled; it appears once scanning starts.
        en    = 1'b0;
        #1 rst_n = 1'b1;
        upd   = 1'b1;
        din   = CODES_A;
        @(posedge clk);
        #1 chk_blank("dis0");
        upd   = 1'b0;
        din   = '0;
        @(posedge clk);
        #1 chk_blank("dis1");
        en    = 1'b1;

        // Scan order, tear-free update, coincident update, blink.
        for (int k = 1; k <= 416; k++) begin
            int j;
            j    = k - 1;
            upd  = (j == 50) || (j == 80) || (j == 95);
            din  = (j == 50) ? CODES_B : (j == 80) ? CODES_C : (j == 95) ? CODES_F : CODES_Z;
            drop = (j >= 160) && (j < 360);
            @(posedge clk);
            #1;
            exp_codes = (j < 64) ? CODES_A : (j < 96) ? CODES_B : CODES_F;
            blank     = ((j >= 224) && (j < 288)) || ((j >= 352) && (j <= 360));
            if (!((j > 360) && (j < 384))) step_chk(k, exp_codes, blank);
        end
        upd  = 1'b0;
        din  = '0;
        drop = 1'b0;

        // Enable gating with an update captured while disabled.
        for (int i = 0; i < 5; i++) begin
            en  = 1'b0;
            upd = (i == 2);
            din = (i == 2) ? CODES_D : CODES_Z;
            @(posedge clk);
            #1 chk_blank($sformatf("en_off%0d", i));
        end
        upd = 1'b0;
        din = '0;
        en  = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1 step_chk(k, CODES_D, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
